shared_timer_arbiter: RTL
=========================

Name: shared_timer_arbiter

Overview:
Round-robin controller that shares one prescaled modulo-N tick counter among NREQ requesters. Each requester asks for a delay measured in ticks. The block grants the timer to one requester at a time, sequences load/count/terminal-count, and returns a one-cycle done pulse. It sits between board-level sequencers (LED patterns, debouncers, PLL-lock waits) and the single timer datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
CNT_W, 16, width of each requested delay and of the tick counter
PRESCALE, 25, clk cycles per tick (>=1); prescaler width is $clog2(PRESCALE), minimum 1 bit

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
req  input  NREQ  per-requester request level; hold high until done
delay  input  NREQ*CNT_W  requested tick count, requester i at bits [i*CNT_W +: CNT_W]
abort  input  1  global cancel of the running timer
grant  output  NREQ  one-hot owner of the timer; all zero when idle
busy  output  1  high in RUN and DONE
done  output  NREQ  one-cycle pulse to the owner on terminal count
tick_count  output  CNT_W  current tick count of the active timer; 0 when idle

Behaviour:
Reset (async, rst_n low):
- State goes to IDLE.
- grant, done, busy, tick_count and the prescaler all go to 0.
- Round-robin pointer goes to 0, so requester 0 has highest priority first.

States: IDLE, RUN, DONE.

IDLE:
- If req != 0, the winner is the first set req bit searching upward (wrapping) from the pointer index.
- At the next edge: state becomes RUN, grant becomes onehot(winner), and the winner's delay is latched as max(delay,1).
- tick_count and the prescaler are cleared.
- Latency from req sampled high to grant high is 1 cycle.

RUN:
- The prescaler counts 0..PRESCALE-1 and wraps. A tick occurs when prescaler == PRESCALE-1.
- On each tick, tick_count increments by 1.
- On the tick where tick_count == latched-1, the next state is DONE. tick_count then holds the latched value.
- Total RUN duration is latched*PRESCALE cycles.
- Changes on the owner's delay bus after the grant are ignored.

DONE (exactly 1 cycle):
- done[owner] = 1.
- At the next edge: grant clears, tick_count clears, the pointer becomes (owner+1) mod NREQ, and state becomes IDLE.

Re-arbitration:
- IDLE always lasts at least 1 cycle between grants, so the minimum gap between grants is 1 cycle with grant low.
- A requester that keeps req high after done is re-arbitrated behind the others (fairness).

Cancel:
- Applies in RUN when abort = 1 or req[owner] falls.
- At the next edge: state becomes IDLE, grant, tick_count and the prescaler clear, and the pointer advances past the owner.
- No done pulse is issued.
- If cancel coincides with the terminal tick, cancel wins and no done is issued.
- abort in IDLE or DONE has no effect; a DONE pulse already in progress completes.

Other rules:
- Requests raised by non-owners during RUN wait; they are not lost because they are level requests.
- Delay value 0 is treated as 1 tick.
- Delay value 2^CNT_W-1 must complete without wrap.
- tick_count compare uses CNT_W bits.
- Only one grant bit and at most one done bit may be high at any time.
- done[i] may only be high while grant[i] is high.

Test Plan:
PRESCALE=4, CNT_W=8, NREQ=4 for all scenarios.
1. Reset with rst_n low mid-RUN → grant, done, busy, tick_count = 0 immediately (asynchronously); after release, req=0001 is granted first.
2. req=0001, delay0=3 at cycle 0 → grant=0001 at cycle 1; done[0] pulses exactly 12 cycles after grant rises; tick_count reads 1, 2, 3; grant low 1 cycle after done.
3. req=1111 held continuously, delays all 1 → grant order 0,1,2,3,0; each grant lasts 4 RUN cycles plus 1 DONE cycle; 1 idle cycle between grants.
4. delay2=0, req=0100 → treated as 1 tick; done[2] 4 cycles after grant.
5. Owner 1 running delay 5; abort pulsed at tick 2 → no done; grant clears next edge; pending req3 granted 1 cycle after IDLE is entered; pointer now at 2.
6. Owner drops req on the same cycle as the terminal tick → no done pulse, return to IDLE; assertions check one-hot grant and done implies grant.

Source files
------------

// File: rtl/shared_timer_arbiter.sv
// shared_timer_arbiter: round-robin arbiter that lends one prescaled tick counter to NREQ requesters
module shared_timer_arbiter #(
  parameter int NREQ     = 4,
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] delay,
  input  logic                  abort,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [NREQ-1:0]       done,
  output logic [CNT_W-1:0]      tick_count
);
  localparam int IW = $clog2(NREQ);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  logic [NREQ-1:0]  r_grant, r_done;
  logic [IW-1:0]    r_owner, r_ptr, w_win, w_next;
  logic [CNT_W-1:0] r_tick, r_lat, w_dly;
  logic [PW-1:0]    r_pre;
  logic [IW:0]      w_idx;
  logic             w_tk, w_cancel;
  // Scan downward so the requester closest above the pointer is the last (winning) write.
  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (IW+1)'(k);
      w_idx = w_idx >= (IW+1)'(NREQ) ? w_idx - (IW+1)'(NREQ) : w_idx;
      w_win = req[w_idx[IW-1:0]] ? w_idx[IW-1:0] : w_win;
    end
  end
  assign w_next   = r_owner == IW'(NREQ - 1) ? '0 : r_owner + IW'(1);
  assign w_dly    = delay[w_win*CNT_W +: CNT_W];
  assign w_tk     = r_pre == PW'(PRESCALE - 1);
  assign w_cancel = abort || !req[r_owner];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_tick  <= '0;
      r_lat   <= '0;
      r_pre   <= '0;
    end else begin
      case (r_state)
        IDLE: if (|req) begin
          r_state <= RUN;
          r_grant <= NREQ'(1) << w_win;
          r_owner <= w_win;
          r_lat   <= w_dly == '0 ? CNT_W'(1) : w_dly;
          r_tick  <= '0;
          r_pre   <= '0;
        end
        RUN: if (w_cancel) begin
          r_state <= IDLE;
          r_grant <= '0;
          r_tick  <= '0;
          r_pre   <= '0;
          r_ptr   <= w_next;
        end else begin
          r_pre <= w_tk ? '0 : r_pre + PW'(1);
          if (w_tk) begin
            r_tick <= r_tick + CNT_W'(1);
            if (r_tick == r_lat - CNT_W'(1)) begin
              r_state <= DONE;
              r_done  <= r_grant;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_done  <= '0;
          r_grant <= '0;
          r_tick  <= '0;
          r_pre   <= '0;
          r_ptr   <= w_next;
        end
      endcase
    end
  end
  assign grant      = r_grant;
  assign done       = r_done;
  assign busy       = r_state != IDLE;
  assign tick_count = r_tick;
endmodule
